// File: rtl/seg7_scan_controller_pkg.sv
// rtl/seg7_scan_controller_pkg.sv - shared types, constants and leading-zero mask for the digit scanner
package seg7_scan_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK  = 7'b0000000;
    localparam int         MAX_DIGITS = 16;

    // Bit i set means digit i is a leading zero to be blanked. Digit 0 never is,
    // and a set decimal point ends the leading run just like a nonzero digit.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] digits,
        input logic [MAX_DIGITS-1:0]   dps,
        input int                      n,
        input logic                    lz_en
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  leading;
        mask    = '0;
        leading = lz_en;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                if ((digits[4*i +: 4] != 4'd0) || dps[i]) begin
                    leading = 1'b0;
                end
                mask[i] = leading;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable down-counter, done while the count sits at zero
module scan_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/segment7_decoder.sv
// rtl/segment7_decoder.sv - BCD to active-high {a,b,c,d,e,f,g} segment pattern
module segment7_decoder (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            default: seg = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/seg7_scan_controller.sv
// rtl/seg7_scan_controller.sv - multiplexes NUM_DIGITS BCD digits onto one registered 7-segment bus
module seg7_scan_controller
    import seg7_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMR_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] SCAN_LOAD  = TMR_W'(SCAN_DIV - 1);
    localparam logic [TMR_W-1:0] BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e               state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   snap_q;
    logic [NUM_DIGITS-1:0]     snap_dp_q;
    logic                      snap_load;

    logic                      tmr_clr, tmr_load, tmr_done;
    logic [TMR_W-1:0]          tmr_val;

    logic [3:0]                dec_bcd;
    logic [6:0]                dec_seg, show_seg;
    logic [4*MAX_DIGITS-1:0]   snap_ext;
    logic [MAX_DIGITS-1:0]     dp_ext, supp_mask;

    logic [6:0]                seg_d;
    logic                      dp_d, fs_d;
    logic [NUM_DIGITS-1:0]     an_d;

    scan_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign dec_bcd = snap_q[4*idx_q +: 4];

    segment7_decoder u_dec (
        .bcd (dec_bcd),
        .seg (dec_seg)
    );

    always_comb begin
        snap_ext                   = '0;
        dp_ext                     = '0;
        snap_ext[4*NUM_DIGITS-1:0] = snap_q;
        dp_ext[NUM_DIGITS-1:0]     = snap_dp_q;
        supp_mask                  = lz_mask(snap_ext, dp_ext, NUM_DIGITS, lz_en);
        show_seg                   = supp_mask[idx_q] ? SEG_BLANK : dec_seg;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_load = 1'b0;
        tmr_clr   = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = BLANK_LOAD;
        seg_d     = SEG_BLANK;
        dp_d      = 1'b0;
        an_d      = '1;
        fs_d      = 1'b0;

        if (!en) begin
            state_d = IDLE;
            idx_d   = '0;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = BLANK;
                    idx_d     = '0;
                    snap_load = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = BLANK_LOAD;
                end
                BLANK: begin
                    if (tmr_done) begin
                        state_d     = SHOW;
                        tmr_load    = 1'b1;
                        tmr_val     = SCAN_LOAD;
                        an_d[idx_q] = 1'b0;
                        seg_d       = show_seg;
                        dp_d        = snap_dp_q[idx_q];
                        fs_d        = (idx_q == '0);
                    end
                end
                SHOW: begin
                    if (tmr_done) begin
                        state_d  = BLANK;
                        tmr_load = 1'b1;
                        tmr_val  = BLANK_LOAD;
                        // New frame snapshot lands on the same edge idx returns to 0.
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            snap_load = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        an_d[idx_q] = 1'b0;
                        seg_d       = show_seg;
                        dp_d        = snap_dp_q[idx_q];
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            snap_dp_q   <= '0;
            seg         <= SEG_BLANK;
            dp          <= 1'b0;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            if (snap_load) begin
                snap_q    <= digits_in;
                snap_dp_q <= dp_in;
            end
            seg         <= seg_d;
            dp          <= dp_d;
            an_n        <= an_d;
            frame_start <= fs_d;
        end
    end

endmodule
